multi_clock_gate_ctrl: RTL and testbench
========================================

MULTI_CLOCK_GATE_CTRL -- requirements
Module: multi_clock_gate_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independently gated clock channels (1..16).
REQ-002 SHALL have parameter IDLE_CNT_W, default 8: width of the idle counter and the idle threshold.
REQ-003 SHALL have parameter WAKE_CYCLES, default 2: settle cycles between ungating and ack (1..15).
REQ-004 SHALL have port clk_i  input  1  single block clock, the source of every gated clock.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port test_en_i  input  1  scan/test enable; forces every clk_o to follow clk_i.
REQ-007 SHALL have port sw_en_i  input  NUM_CH  per-channel software permit; 0 forces the channel gated.
REQ-008 SHALL have port auto_en_i  input  NUM_CH  per-channel automatic idle-gating enable.
REQ-009 SHALL have port busy_i  input  NUM_CH  per-channel activity indication.
REQ-010 SHALL have port idle_thr_i  input  IDLE_CNT_W  shared idle threshold in cycles; 0 disables auto-gating.
REQ-011 SHALL have port wake_req_i  input  NUM_CH  per-channel wake request, held high until acked.
REQ-012 SHALL have port wake_ack_o  output  NUM_CH  per-channel wake acknowledge.
REQ-013 SHALL have port gated_o  output  NUM_CH  per-channel status: 1 = clock currently gated.
REQ-014 SHALL have port clk_o  output  NUM_CH  per-channel gated clocks.

Function
REQ-015 Each channel SHALL run an independent FSM with states OFF, WAKE, ON, IDLE.
REQ-016 Gating-cell enable SHALL be a registered decode: 1 in WAKE, ON, IDLE; 0 in OFF. No combinational path from inputs to the cell enable.
REQ-017 OFF -> WAKE when wake_req_i=1 and sw_en_i=1. The wake counter loads WAKE_CYCLES-1.
REQ-018 WAKE SHALL decrement the wake counter each cycle and go to ON on the cycle it equals 0.
REQ-019 The total wake latency SHALL be 1+WAKE_CYCLES cycles from the wake_req_i sample edge to entry into ON.
REQ-020 wake_ack_o SHALL be 1 exactly when the state is ON and wake_req_i=1. It SHALL be 0 in every other state.
REQ-021 ON -> IDLE when auto_en_i=1, idle_thr_i!=0, busy_i=0 and wake_req_i=0. The idle counter clears to 0.
REQ-022 IDLE SHALL increment the idle counter each cycle. On busy_i=1 or wake_req_i=1 it returns to ON and clears the counter.
REQ-023 IDLE -> OFF on the cycle the idle counter equals idle_thr_i-1, giving thr idle cycles before gating.
REQ-024 The idle counter SHALL saturate and never wrap.
REQ-025 A change of idle_thr_i during IDLE SHALL take effect on the next compare.
REQ-026 Clearing auto_en_i in IDLE SHALL return the channel to ON.
REQ-027 sw_en_i=0 SHALL force the next state to OFF from any state; this has the highest priority and aborts WAKE.
REQ-028 busy_i in OFF SHALL NOT ungate the channel; only wake_req_i ungates.
REQ-029 If busy_i=1 and wake_req_i=1 arrive simultaneously in IDLE, the transition SHALL be to ON (the same action).
REQ-030 gated_o SHALL equal (state==OFF); it is registered and has no test_en_i influence.
REQ-031 test_en_i SHALL be passed to each gating cell only. It SHALL NOT alter FSM state, counters, wake_ack_o or gated_o.

Reset
REQ-032 rst_i SHALL asynchronously set every channel to OFF, both counters to 0, wake_ack_o to 0 and gated_o to all-ones.
REQ-033 During reset and after reset, clk_o SHALL be low unless test_en_i=1.
REQ-034 Reset asserted mid-WAKE or mid-IDLE SHALL abort to OFF; no ack SHALL be issued.

Structure
REQ-035 A shared package SHALL hold the channel FSM state enum, the default parameter constants and the WAKE_CYCLES range check.
REQ-036 A per-channel sub-module clock_gate_chan_ctrl SHALL hold the FSM, the counters and one technology clock-gate cell instance. The top SHALL be a generate loop over NUM_CH.
REQ-037 The top SHALL flag WAKE_CYCLES=0 or NUM_CH=0 with an elaboration-time error.

Verification
REQ-038 Reset, then sw_en=1 and wake_req[0]=1 at cycle 0 with WAKE_CYCLES=2 -> clk_o[0] toggles from cycle 1, wake_ack_o[0]=1 at cycle 3, gated_o[0]=0 from cycle 1.
REQ-039 ON with auto_en=1, idle_thr=5, busy=0 from cycle 0 -> gated_o=1 after 6 cycles (1 + 5 idle); busy=1 at idle count 3 -> back to ON, counter 0.
REQ-040 sw_en[2] dropped during WAKE -> channel 2 OFF next cycle, no wake_ack_o[2], other channels unaffected.
REQ-041 All channels OFF, test_en_i=1 -> all clk_o toggle, gated_o stays 4'b1111, wake_ack_o stays 0.
REQ-042 idle_thr=0 with auto_en=1, busy=0 for 300 cycles -> channel stays ON, no gating.
REQ-043 rst_i pulsed asynchronously mid-IDLE -> gated_o=all-ones and clk_o low immediately, before the next clk_i edge.

Source files
------------

// File: rtl/multi_clock_gate_ctrl_pkg.sv
// Shared definitions for the multi-channel clock gating controller:
// channel FSM states, default parameters and parameter range checks.
package multi_clock_gate_ctrl_pkg;

   typedef enum logic [1:0] {
      CH_OFF  = 2'd0,
      CH_WAKE = 2'd1,
      CH_ON   = 2'd2,
      CH_IDLE = 2'd3
   } ch_state_e;

   localparam int DEF_NUM_CH      = 4;
   localparam int DEF_IDLE_CNT_W  = 8;
   localparam int DEF_WAKE_CYCLES = 2;
   localparam int WAKE_CNT_W      = 4;

   function automatic bit wake_cycles_ok(input int wake_cycles);
      return (wake_cycles >= 1) && (wake_cycles <= 15);
   endfunction

   function automatic bit num_ch_ok(input int num_ch);
      return (num_ch >= 1) && (num_ch <= 16);
   endfunction

endpackage

// File: rtl/multi_clock_gate_ctrl_chan.sv
// One gated clock channel: OFF/WAKE/ON/IDLE controller, wake and idle
// counters, and the latch-based clock gate cell it drives.
module clock_gate_cell (
   input  logic clk_i,
   input  logic clr_i,
   input  logic en_i,
   input  logic test_en_i,
   output logic clk_o
);
   logic en_lat;

   // Enable is captured while the clock is low so clk_o never glitches.
   always_latch begin
      if (!clk_i) en_lat <= en_i | test_en_i;
   end

   // clr_i kills the output at once so reset does not wait for a low phase.
   assign clk_o = clk_i & en_lat & (~clr_i | test_en_i);
endmodule

module clock_gate_chan_ctrl
   import multi_clock_gate_ctrl_pkg::*;
#(
   parameter int IDLE_CNT_W  = DEF_IDLE_CNT_W,
   parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  test_en_i,
   input  logic                  sw_en_i,
   input  logic                  auto_en_i,
   input  logic                  busy_i,
   input  logic [IDLE_CNT_W-1:0] idle_thr_i,
   input  logic                  wake_req_i,
   output logic                  wake_ack_o,
   output logic                  gated_o,
   output logic                  clk_o
);
   localparam logic [WAKE_CNT_W-1:0] WAKE_LOAD = WAKE_CNT_W'(WAKE_CYCLES - 1);

   ch_state_e               state_q, state_d;
   logic [WAKE_CNT_W-1:0]   wake_cnt_q, wake_cnt_d;
   logic [IDLE_CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic                    cg_en_q;
   logic                    gated_q;

   always_comb begin
      state_d    = state_q;
      wake_cnt_d = wake_cnt_q;
      idle_cnt_d = idle_cnt_q;
      if (!sw_en_i) begin
         state_d    = CH_OFF;
         wake_cnt_d = '0;
         idle_cnt_d = '0;
      end else begin
         case (state_q)
            CH_OFF: begin
               if (wake_req_i) begin
                  state_d    = CH_WAKE;
                  wake_cnt_d = WAKE_LOAD;
               end
            end
            CH_WAKE: begin
               if (wake_cnt_q == '0) state_d = CH_ON;
               else                  wake_cnt_d = wake_cnt_q - 1'b1;
            end
            CH_ON: begin
               if (auto_en_i && (idle_thr_i != '0) && !busy_i && !wake_req_i) begin
                  state_d    = CH_IDLE;
                  idle_cnt_d = '0;
               end
            end
            CH_IDLE: begin
               // A threshold lowered below the running count still gates.
               if (busy_i || wake_req_i || !auto_en_i || (idle_thr_i == '0)) begin
                  state_d    = CH_ON;
                  idle_cnt_d = '0;
               end else if (idle_cnt_q >= (idle_thr_i - IDLE_CNT_W'(1))) begin
                  state_d    = CH_OFF;
                  idle_cnt_d = '0;
               end else if (idle_cnt_q != '1) begin
                  idle_cnt_d = idle_cnt_q + 1'b1;
               end
            end
            default: state_d = CH_OFF;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= CH_OFF;
         wake_cnt_q <= '0;
         idle_cnt_q <= '0;
         cg_en_q    <= 1'b0;
         gated_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         wake_cnt_q <= wake_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         cg_en_q    <= (state_d != CH_OFF);
         gated_q    <= (state_d == CH_OFF);
      end
   end

   assign wake_ack_o = (state_q == CH_ON) && wake_req_i;
   assign gated_o    = gated_q;

   clock_gate_cell u_cg (
      .clk_i     (clk_i),
      .clr_i     (rst_i),
      .en_i      (cg_en_q),
      .test_en_i (test_en_i),
      .clk_o     (clk_o)
   );
endmodule

// File: rtl/multi_clock_gate_ctrl.sv
// Top level: NUM_CH independent gated clock channels sharing one source
// clock, reset, test enable and idle threshold.
module multi_clock_gate_ctrl
   import multi_clock_gate_ctrl_pkg::*;
#(
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int IDLE_CNT_W  = DEF_IDLE_CNT_W,
   parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  test_en_i,
   input  logic [NUM_CH-1:0]     sw_en_i,
   input  logic [NUM_CH-1:0]     auto_en_i,
   input  logic [NUM_CH-1:0]     busy_i,
   input  logic [IDLE_CNT_W-1:0] idle_thr_i,
   input  logic [NUM_CH-1:0]     wake_req_i,
   output logic [NUM_CH-1:0]     wake_ack_o,
   output logic [NUM_CH-1:0]     gated_o,
   output logic [NUM_CH-1:0]     clk_o
);
   if (!wake_cycles_ok(WAKE_CYCLES) || !num_ch_ok(NUM_CH)) begin : g_param_err
      $error("multi_clock_gate_ctrl: WAKE_CYCLES must be 1..15 and NUM_CH 1..16");
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      clock_gate_chan_ctrl #(
         .IDLE_CNT_W  (IDLE_CNT_W),
         .WAKE_CYCLES (WAKE_CYCLES)
      ) u_chan (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .test_en_i  (test_en_i),
         .sw_en_i    (sw_en_i[gi]),
         .auto_en_i  (auto_en_i[gi]),
         .busy_i     (busy_i[gi]),
         .idle_thr_i (idle_thr_i),
         .wake_req_i (wake_req_i[gi]),
         .wake_ack_o (wake_ack_o[gi]),
         .gated_o    (gated_o[gi]),
         .clk_o      (clk_o[gi])
      );
   end
endmodule

// File: tb/tb_multi_clock_gate_ctrl.sv
// Scoreboard bench for multi_clock_gate_ctrl: per-cycle expected gated/ack
// values are queued with the stimulus and compared after each clock edge.
module tb_multi_clock_gate_ctrl;
   localparam int NCH = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           test_en;
   logic [NCH-1:0] sw_en, auto_en, busy, wake_req;
   logic [7:0]     thr;
   logic [NCH-1:0] ack, gated, clk_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string          tag;
      logic [NCH-1:0] gated;
      logic [NCH-1:0] ack;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   multi_clock_gate_ctrl #(
      .NUM_CH      (NCH),
      .IDLE_CNT_W  (8),
      .WAKE_CYCLES (2)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .test_en_i  (test_en),
      .sw_en_i    (sw_en),
      .auto_en_i  (auto_en),
      .busy_i     (busy),
      .idle_thr_i (thr),
      .wake_req_i (wake_req),
      .wake_ack_o (ack),
      .gated_o    (gated),
      .clk_o      (clk_o)
   );

   for (genvar gi = 0; gi < NCH; gi++) begin : g_tog
      int cnt = 0;
      always @(posedge clk_o[gi]) cnt <= cnt + 1;
   end

   function automatic int tog(input int ch);
      case (ch)
         0:       return g_tog[0].cnt;
         1:       return g_tog[1].cnt;
         2:       return g_tog[2].cnt;
         default: return g_tog[3].cnt;
      endcase
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [NCH-1:0] g, input logic [NCH-1:0] a,
                       input int n = 1);
      exp_t e;
      e.tag = tag; e.gated = g; e.ack = a;
      repeat (n) sb.push_back(e);
   endtask

   task automatic run_sb();
      exp_t e;
      while (sb.size() > 0) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         check_val({e.tag, "_gated"}, 32'(gated), 32'(e.gated));
         check_val({e.tag, "_ack"},   32'(ack),   32'(e.ack));
         $display("cycle %-12s gated=%b ack=%b", e.tag, gated, ack);
      end
   endtask

   int s0, s1;
   int snap[NCH];

   initial begin
      rst = 1'b1; test_en = 1'b0; sw_en = '0; auto_en = '0; busy = '0;
      thr = '0; wake_req = '0;
      @(posedge clk); #1;
      check_val("rst_gated", 32'(gated), 32'hF);
      check_val("rst_ack",   32'(ack),   32'h0);
      check_val("rst_clk_o", 32'(clk_o), 32'h0);

      // wake channel 0: WAKE, WAKE, ON with ack on the third edge
      rst = 1'b0; sw_en = 4'hF; wake_req = 4'h1; s0 = tog(0); s1 = tog(1);
      push("wake0_w1", 4'hE, 4'h0);
      push("wake0_w2", 4'hE, 4'h0);
      push("wake0_on", 4'hE, 4'h1);
      run_sb();
      check_val("wake0_clk_runs",  32'(tog(0) - s0 >= 2), 32'h1);
      check_val("wake0_clk1_idle", 32'(tog(1) - s1), 32'h0);
      wake_req = 4'h0; #1;
      check_val("wake0_ack_drop", 32'(ack), 32'h0);

      // wake 1..3, drop sw_en[2] mid-WAKE
      wake_req = 4'hE;
      push("sw2_w1", 4'h0, 4'h0);
      run_sb();
      sw_en = 4'hB;
      push("sw2_abort", 4'h4, 4'h0);
      push("sw2_on",    4'h4, 4'hA);
      run_sb();
      wake_req = 4'h0; sw_en = 4'hF;
      push("sw2_hold", 4'h4, 4'h0);
      run_sb();

      // auto idle on channel 0, threshold 5: gated on the sixth edge
      auto_en = 4'h1; thr = 8'd5;
      push("idle_wait", 4'h4, 4'h0, 5);
      push("idle_gate", 4'h5, 4'h0);
      run_sb();
      wake_req = 4'h1;
      push("rewake",    4'h5 & 4'h4, 4'h0, 2);
      push("rewake_on", 4'h4, 4'h1);
      run_sb();
      wake_req = 4'h0;
      push("busy_idle", 4'h4, 4'h0, 4);
      run_sb();
      busy = 4'h1;
      push("busy_on", 4'h4, 4'h0);
      run_sb();
      busy = 4'h0;
      push("busy_reidle", 4'h4, 4'h0, 5);
      push("busy_gate",   4'h5, 4'h0);
      run_sb();
      auto_en = 4'h0; thr = 8'd0;

      // all off, then test enable forces every clock
      sw_en = 4'h0;
      push("all_off", 4'hF, 4'h0);
      run_sb();
      test_en = 1'b1; wake_req = 4'hF;
      for (int c = 0; c < NCH; c++) snap[c] = tog(c);
      push("test_en", 4'hF, 4'h0, 4);
      run_sb();
      for (int c = 0; c < NCH; c++)
         check_val($sformatf("test_en_clk%0d", c), 32'(tog(c) - snap[c] >= 3), 32'h1);
      test_en = 1'b0; wake_req = 4'h0;
      for (int c = 0; c < NCH; c++) snap[c] = tog(c);
      push("test_off", 4'hF, 4'h0, 3);
      run_sb();
      for (int c = 0; c < NCH; c++)
         check_val($sformatf("test_off_clk%0d", c), 32'(tog(c) - snap[c]), 32'h0);

      // threshold 0 disables auto gating
      sw_en = 4'hF; wake_req = 4'hF;
      push("thr0_w",  4'h0, 4'h0, 2);
      push("thr0_on", 4'h0, 4'hF);
      run_sb();
      wake_req = 4'h0; auto_en = 4'hF; thr = 8'd0; s1 = tog(1);
      push("thr0_hold", 4'h0, 4'h0, 300);
      run_sb();
      check_val("thr0_clk_runs", 32'(tog(1) - s1 >= 299), 32'h1);

      // asynchronous reset in the middle of IDLE
      thr = 8'd8;
      push("ar_idle", 4'h0, 4'h0, 2);
      run_sb();
      #2 rst = 1'b1;
      #1;
      check_val("ar_gated", 32'(gated), 32'hF);
      check_val("ar_clk_o", 32'(clk_o), 32'h0);
      check_val("ar_ack",   32'(ack),   32'h0);
      #2 rst = 1'b0;
      push("ar_after", 4'hF, 4'h0);
      run_sb();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
